mmmul_lanes: RTL and testbench

Parametrised successor to the matrix multiplier: computes C = A·B, or C += A·B in accumulate mode, over signed fixed-width integers. It uses LANES parallel multiply-accumulate units, so each pass produces LANES adjacent output columns. It takes a start/busy/done handshake and a saturation flag, and is the general matrix stage feeding the dense-layer datapath.

---
 rtl/mmmul_lanes.sv | 254 +++++++++++++++++++++++++
 tb/tb_mmmul_lanes.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmmul_lanes.sv
// mmmul_lanes
// Signed fixed-width matrix multiplier. It computes C = A*B, or C += A*B in
// accumulate mode. LANES multiply-accumulate units work side by side, so each
// pass produces LANES adjacent output columns of one result row.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset; clears result and all state
//   start       request a run; only looked at while idle
//   accumulate  captured with start: 0 -> C = A*B, 1 -> C += A*B
//   matrix1     A, [ROWS1][COLS1] elements of DATA_W bits, held while busy
//   matrix2     B, [COLS1][COLS2] elements, row-major, held while busy
//   result      C, [ROWS1][COLS2] registered elements
//   busy        high while passes are running
//   done        one-cycle pulse after the final write
//   sat         some written element was clipped during the last run
module mmmul_lanes #(
    parameter int ROWS1  = 4,
    parameter int COLS1  = 4,
    parameter int COLS2  = 4,
    parameter int DATA_W = 32,
    parameter int LANES  = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic                                    accumulate,
    input  logic [ROWS1-1:0][COLS1-1:0][DATA_W-1:0] matrix1,
    input  logic [COLS1-1:0][COLS2-1:0][DATA_W-1:0] matrix2,
    output logic [ROWS1-1:0][COLS2-1:0][DATA_W-1:0] result,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    sat
);

    // The extra $clog2(COLS1)+1 bits keep a full dot product plus the
    // preloaded old element from ever wrapping inside the accumulator.
    localparam int ACC_W  = 2*DATA_W + $clog2(COLS1) + 1;
    localparam int PROD_W = 2*DATA_W;
    localparam int R_W    = (ROWS1 > 1) ? $clog2(ROWS1) : 1;
    localparam int K_W    = (COLS1 > 1) ? $clog2(COLS1) : 1;
    localparam int C_W    = $clog2(COLS2 + LANES) + 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        WRITE,
        DONE
    } state_t;

    state_t                                  state_q, state_d;
    logic [R_W-1:0]                          r_q, r_d;
    logic [C_W-1:0]                          c0_q, c0_d;
    logic [K_W-1:0]                          k_q, k_d;
    logic                                    acc_mode_q, acc_mode_d;
    logic                                    busy_q, busy_d;
    logic                                    done_q, done_d;
    logic                                    sat_q, sat_d;
    logic [ROWS1-1:0][COLS2-1:0][DATA_W-1:0] result_q, result_d;
    logic signed [ACC_W-1:0]                 acc_q [LANES];
    logic signed [ACC_W-1:0]                 acc_d [LANES];

    logic [DATA_W-1:0]       a_elem;
    logic [PROD_W-1:0]       a_ext;
    int                      lane_col  [LANES];
    logic                    lane_on   [LANES];
    logic [DATA_W-1:0]       b_elem    [LANES];
    logic [DATA_W-1:0]       old_elem  [LANES];
    logic [PROD_W-1:0]       b_ext     [LANES];
    logic [PROD_W-1:0]       prod      [LANES];
    logic signed [ACC_W-1:0] prod_ext  [LANES];
    logic signed [ACC_W-1:0] acc_base  [LANES];
    logic signed [ACC_W-1:0] acc_next  [LANES];
    logic [DATA_W-1:0]       clip_val  [LANES];
    logic                    clipped   [LANES];

    // Operand selection, lane products and saturation. Elements are picked
    // with compare-and-select loops so the lane column, which can run past
    // COLS2 on the last pass of a row, never indexes outside the arrays.
    // Masked lanes see B = 0 and are simply never written back.
    always_comb begin
        a_elem = '0;
        for (int i = 0; i < ROWS1; i++) begin
            for (int j = 0; j < COLS1; j++) begin
                if (i == int'(r_q) && j == int'(k_q)) begin
                    a_elem = matrix1[i][j];
                end
            end
        end
        a_ext = {{DATA_W{a_elem[DATA_W-1]}}, a_elem};

        for (int l = 0; l < LANES; l++) begin
            lane_col[l] = int'(c0_q) + l;
            lane_on[l]  = (lane_col[l] < COLS2);
            b_elem[l]   = '0;
            old_elem[l] = '0;
            for (int c = 0; c < COLS2; c++) begin
                if (c == lane_col[l]) begin
                    for (int j = 0; j < COLS1; j++) begin
                        if (j == int'(k_q)) begin
                            b_elem[l] = matrix2[j][c];
                        end
                    end
                    for (int i = 0; i < ROWS1; i++) begin
                        if (i == int'(r_q)) begin
                            old_elem[l] = result_q[i][c];
                        end
                    end
                end
            end

            // Both operands are sign-extended to the full product width, so
            // the low 2*DATA_W bits of the plain multiply are the signed product.
            b_ext[l]    = {{DATA_W{b_elem[l][DATA_W-1]}}, b_elem[l]};
            prod[l]     = a_ext * b_ext[l];
            prod_ext[l] = {{(ACC_W-PROD_W){prod[l][PROD_W-1]}}, prod[l]};

            acc_base[l] = acc_mode_q ? {{(ACC_W-DATA_W){old_elem[l][DATA_W-1]}}, old_elem[l]}
                                     : '0;
            acc_next[l] = (k_q == '0) ? (acc_base[l] + prod_ext[l])
                                      : (acc_q[l] + prod_ext[l]);

            clipped[l]  = 1'b0;
            clip_val[l] = acc_q[l][DATA_W-1:0];
            if (acc_q[l] > SAT_MAX) begin
                clipped[l]  = 1'b1;
                clip_val[l] = {1'b0, {(DATA_W-1){1'b1}}};
            end else if (acc_q[l] < SAT_MIN) begin
                clipped[l]  = 1'b1;
                clip_val[l] = {1'b1, {(DATA_W-1){1'b0}}};
            end
        end
    end

    // Sequencing: IDLE -> (COLS1 x MAC, WRITE) per pass -> DONE -> IDLE.
    // busy and done are computed from the next state so that, once
    // registered, they line up with the state actually being entered.
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        c0_d       = c0_q;
        k_d        = k_q;
        acc_mode_d = acc_mode_q;
        sat_d      = sat_q;
        result_d   = result_q;
        for (int l = 0; l < LANES; l++) begin
            acc_d[l] = acc_q[l];
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = MAC;
                    acc_mode_d = accumulate;
                    r_d        = '0;
                    c0_d       = '0;
                    k_d        = '0;
                    sat_d      = 1'b0;
                end
            end

            MAC: begin
                for (int l = 0; l < LANES; l++) begin
                    acc_d[l] = acc_next[l];
                end
                if (int'(k_q) == COLS1 - 1) begin
                    k_d     = '0;
                    state_d = WRITE;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end

            WRITE: begin
                for (int l = 0; l < LANES; l++) begin
                    for (int i = 0; i < ROWS1; i++) begin
                        for (int c = 0; c < COLS2; c++) begin
                            if (lane_on[l] && i == int'(r_q) && c == lane_col[l]) begin
                                result_d[i][c] = clip_val[l];
                            end
                        end
                    end
                    if (lane_on[l] && clipped[l]) begin
                        sat_d = 1'b1;
                    end
                end

                if (int'(c0_q) + LANES < COLS2) begin
                    c0_d    = c0_q + C_W'(LANES);
                    state_d = MAC;
                end else if (int'(r_q) + 1 < ROWS1) begin
                    c0_d    = '0;
                    r_d     = r_q + R_W'(1);
                    state_d = MAC;
                end else begin
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == MAC) || (state_d == WRITE);
        done_d = (state_d == DONE);
    end

    // State register; reset wins in every state and wipes the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            r_q        <= '0;
            c0_q       <= '0;
            k_q        <= '0;
            acc_mode_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sat_q      <= 1'b0;
            result_q   <= '0;
            for (int l = 0; l < LANES; l++) begin
                acc_q[l] <= '0;
            end
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            c0_q       <= c0_d;
            k_q        <= k_d;
            acc_mode_q <= acc_mode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sat_q      <= sat_d;
            result_q   <= result_d;
            for (int l = 0; l < LANES; l++) begin
                acc_q[l] <= acc_d[l];
            end
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign sat    = sat_q;

endmodule

// File: tb/tb_mmmul_lanes.sv
// tb_mmmul_lanes
// Three instances of mmmul_lanes: the 4x4x4 default, a 2x2x3 shape with a
// masked final lane, and an 8-bit 2x2x2 shape that saturates. Each issued
// run pushes its expected matrix, sat flag and done cycle into a per-instance
// queue; a negedge monitor per instance pops and compares on every done.
module tb_mmmul_lanes;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic                    start0, acc0, busy0, done0, sat0;
    logic [3:0][3:0][31:0]   m1_0, m2_0, res0;

    logic                    start1, busy1, done1, sat1;
    logic [1:0][1:0][31:0]   m1_1;
    logic [1:0][2:0][31:0]   m2_1, res1;

    logic                    start2, busy2, done2, sat2;
    logic [1:0][1:0][7:0]    m1_2, m2_2, res2;

    mmmul_lanes dut0 (
        .clk(clk), .rst(rst), .start(start0), .accumulate(acc0),
        .matrix1(m1_0), .matrix2(m2_0), .result(res0),
        .busy(busy0), .done(done0), .sat(sat0)
    );

    mmmul_lanes #(.ROWS1(2), .COLS1(2), .COLS2(3), .DATA_W(32), .LANES(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .accumulate(1'b0),
        .matrix1(m1_1), .matrix2(m2_1), .result(res1),
        .busy(busy1), .done(done1), .sat(sat1)
    );

    mmmul_lanes #(.ROWS1(2), .COLS1(2), .COLS2(2), .DATA_W(8), .LANES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .accumulate(1'b0),
        .matrix1(m1_2), .matrix2(m2_2), .result(res2),
        .busy(busy2), .done(done2), .sat(sat2)
    );

    typedef struct {
        int     c [16];
        bit     s;
        longint dc;
        int     nb;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    exp_t   q2[$];
    exp_t   e0, e1, e2;
    int     total = 0;
    int     bad = 0;
    longint cyc = 0;
    int     busy_cnt0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Instance 0 monitor: also counts busy cycles of the current run.
    always @(negedge clk) begin
        if (busy0) busy_cnt0++;
        if (done0) begin
            checkOutput("dut0_done_expected", longint'(q0.size() > 0), 1);
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        checkOutput($sformatf("dut0_c[%0d][%0d]", i, j),
                                    $signed(res0[i][j]), e0.c[i*4+j]);
                checkOutput("dut0_sat", sat0, e0.s);
                checkOutput("dut0_done_cycle", cyc, e0.dc);
                checkOutput("dut0_busy_at_done", busy0, 0);
                checkOutput("dut0_busy_cycles", busy_cnt0, e0.nb);
            end
        end
    end

    // Instance 1 monitor (masked lane shape).
    always @(negedge clk) begin
        if (done1) begin
            checkOutput("dut1_done_expected", longint'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 3; j++)
                        checkOutput($sformatf("dut1_c[%0d][%0d]", i, j),
                                    $signed(res1[i][j]), e1.c[i*3+j]);
                checkOutput("dut1_sat", sat1, e1.s);
                checkOutput("dut1_done_cycle", cyc, e1.dc);
                checkOutput("dut1_busy_at_done", busy1, 0);
            end
        end
    end

    // Instance 2 monitor (8-bit saturating shape).
    always @(negedge clk) begin
        if (done2) begin
            checkOutput("dut2_done_expected", longint'(q2.size() > 0), 1);
            if (q2.size() > 0) begin
                e2 = q2.pop_front();
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++)
                        checkOutput($sformatf("dut2_c[%0d][%0d]", i, j),
                                    $signed(res2[i][j]), e2.c[i*2+j]);
                checkOutput("dut2_sat", sat2, e2.s);
                checkOutput("dut2_done_cycle", cyc, e2.dc);
                checkOutput("dut2_busy_at_done", busy2, 0);
            end
        end
    end

    // Pulses start on one instance for a single cycle. t is the cycle in
    // which start is high; done is expected at t + offset.
    task automatic applyStimulus(input int id, input bit accm, input exp_t e,
                                 input int offset, input bit expect_done,
                                 output longint t);
        @(negedge clk);
        t    = cyc;
        e.dc = cyc + offset;
        if (expect_done) begin
            case (id)
                0: q0.push_back(e);
                1: q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        if (id == 0) busy_cnt0 = 0;
        acc0 = accm;
        case (id)
            0: start0 = 1'b1;
            1: start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int limit);
        int n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput(name, q0.size() + q1.size() + q2.size(), 0);
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_t   e;
        longint t;

        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; acc0 = 1'b0;
        m1_0 = '0; m2_0 = '0; m1_1 = '0; m2_1 = '0; m1_2 = '0; m2_2 = '0;
        for (int i = 0; i < 16; i++) e.c[i] = 0;
        e.s = 1'b0; e.dc = 0; e.nb = 0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy0", busy0, 0);
        checkOutput("reset_done0", done0, 0);
        checkOutput("reset_sat0", sat0, 0);
        checkOutput("reset_result0_nonzero", longint'(res0 != '0), 0);
        checkOutput("reset_busy1", busy1, 0);
        checkOutput("reset_result2_nonzero", longint'(res2 != '0), 0);

        // Identity times B gives B back; 8 passes of 5 cycles.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                m1_0[i][j] = (i == j) ? 32'd1 : 32'd0;
                m2_0[i][j] = 32'(4*i + j);
                e.c[i*4+j] = 4*i + j;
            end
        e.s = 1'b0; e.nb = 40;
        $display("[TB] identity run");
        applyStimulus(0, 1'b0, e, 41, 1'b1, t);
        waitIdle("identity_timeout", 80);

        // Accumulate on top of the previous result: 2*B.
        for (int i = 0; i < 16; i++) e.c[i] = 2 * i;
        $display("[TB] accumulate run");
        applyStimulus(0, 1'b1, e, 41, 1'b1, t);
        waitIdle("accumulate_timeout", 80);

        // A second start pulse in the middle of the run must be dropped.
        for (int i = 0; i < 16; i++) e.c[i] = i;
        $display("[TB] start-while-busy run");
        applyStimulus(0, 1'b0, e, 41, 1'b1, t);
        repeat (4) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        waitIdle("ignored_start_timeout", 80);
        repeat (50) @(negedge clk);
        checkOutput("no_second_run_busy", busy0, 0);

        // Masked lane: third column is handled by lane 0 alone.
        m1_1[0][0] = 32'd1; m1_1[0][1] = 32'd2;
        m1_1[1][0] = 32'd3; m1_1[1][1] = 32'd4;
        m2_1[0][0] = 32'd5; m2_1[0][1] = 32'd6; m2_1[0][2] = 32'd7;
        m2_1[1][0] = 32'd8; m2_1[1][1] = 32'd9; m2_1[1][2] = 32'd10;
        e.c[0] = 21; e.c[1] = 24; e.c[2] = 27;
        e.c[3] = 47; e.c[4] = 54; e.c[5] = 61;
        e.s = 1'b0;
        $display("[TB] masked lane run");
        applyStimulus(1, 1'b0, e, 13, 1'b1, t);
        waitIdle("masked_timeout", 40);

        // 100*100*2 = 20000 clips high; -20000 clips low.
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                m1_2[i][j] = 8'd100;
                m2_2[i][j] = 8'd100;
            end
        for (int i = 0; i < 4; i++) e.c[i] = 127;
        e.s = 1'b1;
        $display("[TB] positive saturation run");
        applyStimulus(2, 1'b0, e, 7, 1'b1, t);
        waitIdle("sat_pos_timeout", 30);

        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                m1_2[i][j] = 8'h9C;
        for (int i = 0; i < 4; i++) e.c[i] = -128;
        $display("[TB] negative saturation run");
        applyStimulus(2, 1'b0, e, 7, 1'b1, t);
        waitIdle("sat_neg_timeout", 30);

        // Reset ten cycles into a run: no done, result wiped.
        $display("[TB] mid-run reset");
        applyStimulus(0, 1'b0, e, 41, 1'b0, t);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", busy0, 0);
        checkOutput("abort_done", done0, 0);
        checkOutput("abort_result0_nonzero", longint'(res0 != '0), 0);
        repeat (45) @(negedge clk);
        checkOutput("abort_still_idle", busy0, 0);

        for (int i = 0; i < 16; i++) e.c[i] = i;
        e.s = 1'b0; e.nb = 40;
        $display("[TB] fresh run after reset");
        applyStimulus(0, 1'b0, e, 41, 1'b1, t);
        waitIdle("fresh_timeout", 80);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
